// File: rtl/lbc_lbus_resp_pkg.sv
// Shared constants for the LBC local-bus responder: source-select bit indices,
// beat-counter width and FSM state encodings.
package lbc_lbus_resp_pkg;

  localparam int unsigned NSEL_DEF = 4;
  localparam int unsigned BEAT_W   = 4;

  localparam int unsigned SRC_EJ = 0;
  localparam int unsigned SRC_I  = 1;
  localparam int unsigned SRC_DR = 2;
  localparam int unsigned SRC_DW = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LATCH   = 3'd1,
    ST_REQ     = 3'd2,
    ST_WAITACK = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

endpackage

// File: rtl/lbc_tgl_sync.sv
// Go detector for the CBUS handshake: 2-flop synchroniser with toggle-edge
// detection (async mode) or a level handshake gated by busy/ack (sync mode).
module lbc_tgl_sync (
  input  logic clk,
  input  logic rst,
  input  logic sync_mode,
  input  logic cgo,
  input  logic busy,
  input  logic ack,
  output logic go_c
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;
  logic ack_pend_q, ack_pend_d;

  always_comb begin
    sync1_d    = cgo;
    sync2_d    = sync1_q;
    prev_d     = sync2_q;
    ack_pend_d = ack_pend_q;
    // One transfer per high phase: block re-triggering until go is seen low.
    if (ack) begin
      ack_pend_d = 1'b1;
    end else if (!cgo) begin
      ack_pend_d = 1'b0;
    end
    go_c = sync_mode ? (cgo & ~busy & ~ack_pend_q) : (sync2_q ^ prev_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      prev_q     <= 1'b0;
      ack_pend_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      prev_q     <= prev_d;
      ack_pend_q <= ack_pend_d;
    end
  end

endmodule

// File: rtl/lbc_lbus_resp.sv
// LBC go/ack responder: runs the selected local-bus transfer and returns a
// one-cycle ack. Optional WAITACK watchdog enabled by LBC_LBUS_TIMEOUT_EN.
module lbc_lbus_resp
  import lbc_lbus_resp_pkg::*;
#(
  parameter int unsigned NSEL   = NSEL_DEF,
  parameter int unsigned IBURST = 4,
  parameter int unsigned TMO_W  = 8
) (
  input  logic            SYSCLK,
  input  logic            RESET_D1_R,
  input  logic            LBCSYNCMODE,
  input  logic            LC_CGO,
  input  logic [NSEL-1:0] LC_CQSEL,
  input  logic            EJ_DMARW,
  input  logic            LL_BACK,
  input  logic            LL_BERR,
  output logic            LD_BREQ,
  output logic            LD_BRW,
  output logic [NSEL-1:0] LD_BSRC,
  output logic [3:0]      LD_BEAT,
  output logic            LD_MEJDEST,
  output logic            LDN_CGOACK_R,
  output logic            LD_BERR_R,
  output logic            LD_BUSY
);

  localparam logic [BEAT_W-1:0] BURST_LAST = BEAT_W'(IBURST - 1);

  if (IBURST < 1 || IBURST > 16 || TMO_W < 1 || NSEL < 4) begin : g_param_chk
    $error("lbc_lbus_resp: illegal parameter value");
  end

  state_e            state_q, state_d;
  logic [NSEL-1:0]   sel_q, sel_d;
  logic              dmarw_q, dmarw_d;
  logic              brw_q, brw_d;
  logic              mej_q, mej_d;
  logic              breq_q, breq_d;
  logic              ack_q, ack_d;
  logic              berr_q, berr_d;
  logic              busy_q, busy_d;
  logic              pend_q, pend_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [BEAT_W-1:0] limit_q, limit_d;
  logic              go_c;
  logic              sel_ok_c;
`ifdef LBC_LBUS_TIMEOUT_EN
  logic [TMO_W-1:0]  tmo_q, tmo_d;
`endif

  lbc_tgl_sync u_tgl_sync (
    .clk       (SYSCLK),
    .rst       (RESET_D1_R),
    .sync_mode (LBCSYNCMODE),
    .cgo       (LC_CGO),
    .busy      (busy_q),
    .ack       (ack_q),
    .go_c      (go_c)
  );

  assign sel_ok_c = (sel_q != '0) && ((sel_q & (sel_q - NSEL'(1))) == '0);

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    dmarw_d = dmarw_q;
    brw_d   = brw_q;
    mej_d   = mej_q;
    berr_d  = berr_q;
    pend_d  = pend_q;
    beat_d  = beat_q;
    limit_d = limit_q;
`ifdef LBC_LBUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    // Async toggles arriving mid-transfer are remembered once and replayed.
    if (go_c && !LBCSYNCMODE && (state_q != ST_IDLE)) begin
      pend_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (go_c || pend_q) begin
          sel_d   = LC_CQSEL;
          dmarw_d = EJ_DMARW;
          berr_d  = 1'b0;
          pend_d  = 1'b0;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        if (!sel_ok_c) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          brw_d   = sel_q[SRC_I] | sel_q[SRC_DR] | (sel_q[SRC_EJ] & dmarw_q);
          mej_d   = sel_q[SRC_EJ];
          beat_d  = '0;
          limit_d = sel_q[SRC_I] ? BURST_LAST : '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
`ifdef LBC_LBUS_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = ST_WAITACK;
      end
      ST_WAITACK: begin
        if (LL_BACK) begin
          berr_d = berr_q | LL_BERR;
`ifdef LBC_LBUS_TIMEOUT_EN
          tmo_d  = '0;
`endif
          if ((beat_q == limit_q) || LL_BERR) begin
            state_d = ST_DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
`ifdef LBC_LBUS_TIMEOUT_EN
        else if (&tmo_q) begin
          berr_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
`endif
      end
      ST_DONE: begin
        mej_d   = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered copies of what the next state implies.
    breq_d = (state_d == ST_REQ) || (state_d == ST_WAITACK);
    ack_d  = (state_d == ST_DONE);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge SYSCLK or posedge RESET_D1_R) begin
    if (RESET_D1_R) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
      dmarw_q <= 1'b0;
      brw_q   <= 1'b0;
      mej_q   <= 1'b0;
      breq_q  <= 1'b0;
      ack_q   <= 1'b0;
      berr_q  <= 1'b0;
      busy_q  <= 1'b0;
      pend_q  <= 1'b0;
      beat_q  <= '0;
      limit_q <= '0;
`ifdef LBC_LBUS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      dmarw_q <= dmarw_d;
      brw_q   <= brw_d;
      mej_q   <= mej_d;
      breq_q  <= breq_d;
      ack_q   <= ack_d;
      berr_q  <= berr_d;
      busy_q  <= busy_d;
      pend_q  <= pend_d;
      beat_q  <= beat_d;
      limit_q <= limit_d;
`ifdef LBC_LBUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  assign LD_BREQ      = breq_q;
  assign LD_BRW       = brw_q;
  assign LD_BSRC      = sel_q;
  assign LD_BEAT      = beat_q;
  assign LD_MEJDEST   = mej_q;
  assign LDN_CGOACK_R = ack_q;
  assign LD_BERR_R    = berr_q;
  assign LD_BUSY      = busy_q;

endmodule

// File: tb/tb_lbc_lbus_resp.sv
// Directed self-checking bench for lbc_lbus_resp (default parameters).
module tb_lbc_lbus_resp;

  logic       SYSCLK = 1'b0;
  logic       RESET_D1_R = 1'b1;
  logic       LBCSYNCMODE = 1'b0;
  logic       LC_CGO = 1'b0;
  logic [3:0] LC_CQSEL = 4'b0000;
  logic       EJ_DMARW = 1'b0;
  logic       LL_BACK = 1'b0;
  logic       LL_BERR = 1'b0;
  logic       LD_BREQ, LD_BRW, LD_MEJDEST, LDN_CGOACK_R, LD_BERR_R, LD_BUSY;
  logic [3:0] LD_BSRC, LD_BEAT;

  int checks = 0;
  int errors = 0;

  int         berr_beat = -1;
  int         obs_breq, obs_ack, obs_first_busy;
  logic       obs_brw, obs_mej_breq, obs_mej_ack, obs_berr_busy;
  logic [3:0] obs_bsrc;
  logic [3:0] obs_beat [0:15];

  lbc_lbus_resp dut (
    .SYSCLK       (SYSCLK),
    .RESET_D1_R   (RESET_D1_R),
    .LBCSYNCMODE  (LBCSYNCMODE),
    .LC_CGO       (LC_CGO),
    .LC_CQSEL     (LC_CQSEL),
    .EJ_DMARW     (EJ_DMARW),
    .LL_BACK      (LL_BACK),
    .LL_BERR      (LL_BERR),
    .LD_BREQ      (LD_BREQ),
    .LD_BRW       (LD_BRW),
    .LD_BSRC      (LD_BSRC),
    .LD_BEAT      (LD_BEAT),
    .LD_MEJDEST   (LD_MEJDEST),
    .LDN_CGOACK_R (LDN_CGOACK_R),
    .LD_BERR_R    (LD_BERR_R),
    .LD_BUSY      (LD_BUSY)
  );

  always #5 SYSCLK = ~SYSCLK;

  // Watch a fixed window of cycles, sampling at negedges, and drive LL_BERR on a chosen beat.
  task automatic observe(input int ncyc);
    obs_breq = 0; obs_ack = 0; obs_first_busy = -1;
    obs_brw = 1'bx; obs_mej_breq = 1'bx; obs_mej_ack = 1'bx; obs_berr_busy = 1'bx;
    obs_bsrc = 4'bx;
    for (int k = 0; k < 16; k++) obs_beat[k] = 4'hf;
    for (int i = 1; i <= ncyc; i++) begin
      @(negedge SYSCLK);
      LL_BERR = (berr_beat >= 0) && LD_BREQ && (int'(LD_BEAT) == berr_beat);
      if (LD_BUSY && obs_first_busy < 0) begin
        obs_first_busy = i;
        obs_berr_busy  = LD_BERR_R;
      end
      if (LD_BREQ) begin
        if (obs_breq < 16) obs_beat[obs_breq] = LD_BEAT;
        obs_brw = LD_BRW; obs_mej_breq = LD_MEJDEST; obs_bsrc = LD_BSRC;
        obs_breq++;
      end
      if (LDN_CGOACK_R) begin
        obs_ack++;
        obs_mej_ack = LD_MEJDEST;
      end
    end
  endtask

  task automatic toggle_go(input logic [3:0] sel, input logic rw);
    @(negedge SYSCLK);
    LC_CQSEL = sel;
    EJ_DMARW = rw;
    LC_CGO   = ~LC_CGO;
  endtask

  task automatic test_reset;
    logic [16:0] outs;
    @(negedge SYSCLK);
    outs = {LD_BREQ, LD_BRW, LD_BSRC, LD_BEAT, LD_MEJDEST, LDN_CGOACK_R, LD_BERR_R, LD_BUSY};
    checks++;
    if (outs !== 17'd0) begin errors++; $display("FAIL reset_outputs got %h want 0", outs); end
    @(negedge SYSCLK);
    RESET_D1_R = 1'b0;
    observe(4);
    checks++;
    if (obs_first_busy != -1) begin errors++; $display("FAIL reset_idle busy_at %0d want -1", obs_first_busy); end
  endtask

  task automatic test_fetch_burst;
    LL_BACK = 1'b1;
    toggle_go(4'b0010, 1'b0);
    observe(14);
    checks++;
    if (obs_first_busy != 3) begin errors++; $display("FAIL async_latency got %0d want 3", obs_first_busy); end
    checks++;
    if (obs_breq != 5) begin errors++; $display("FAIL fetch_breq_cycles got %0d want 5", obs_breq); end
    checks++;
    if ({obs_beat[0], obs_beat[1], obs_beat[2], obs_beat[3], obs_beat[4]} !== 20'h00123) begin
      errors++;
      $display("FAIL fetch_beats got %h want 00123",
               {obs_beat[0], obs_beat[1], obs_beat[2], obs_beat[3], obs_beat[4]});
    end
    checks++;
    if ({obs_brw, obs_mej_breq, obs_bsrc} !== 6'b10_0010) begin
      errors++; $display("FAIL fetch_brw_mej_src got %b want 100010", {obs_brw, obs_mej_breq, obs_bsrc});
    end
    checks++;
    if (obs_ack != 1 || LD_BUSY !== 1'b0 || LD_BERR_R !== 1'b0) begin
      errors++; $display("FAIL fetch_ack got ack=%0d busy=%b berr=%b want 1 0 0", obs_ack, LD_BUSY, LD_BERR_R);
    end
  endtask

  task automatic test_ej_write;
    toggle_go(4'b0001, 1'b0);
    observe(10);
    checks++;
    if (obs_breq != 2 || obs_ack != 1) begin
      errors++; $display("FAIL ej_single got breq=%0d ack=%0d want 2 1", obs_breq, obs_ack);
    end
    checks++;
    if ({obs_brw, obs_mej_breq, obs_mej_ack, LD_MEJDEST} !== 4'b0110) begin
      errors++; $display("FAIL ej_brw_mej got %b want 0110", {obs_brw, obs_mej_breq, obs_mej_ack, LD_MEJDEST});
    end
  endtask

  task automatic test_bad_select;
    toggle_go(4'b0110, 1'b0);
    observe(8);
    checks++;
    if (obs_breq != 0 || obs_ack != 1 || LD_BERR_R !== 1'b1) begin
      errors++; $display("FAIL bad_sel got breq=%0d ack=%0d berr=%b want 0 1 1", obs_breq, obs_ack, LD_BERR_R);
    end
    toggle_go(4'b0100, 1'b0);
    observe(10);
    checks++;
    if (obs_berr_busy !== 1'b0 || LD_BERR_R !== 1'b0) begin
      errors++; $display("FAIL berr_clear got start=%b end=%b want 0 0", obs_berr_busy, LD_BERR_R);
    end
    checks++;
    if (obs_breq != 2 || obs_ack != 1 || obs_brw !== 1'b1 || obs_mej_breq !== 1'b0) begin
      errors++; $display("FAIL data_read got breq=%0d ack=%0d brw=%b mej=%b want 2 1 1 0",
                         obs_breq, obs_ack, obs_brw, obs_mej_breq);
    end
  endtask

  task automatic test_berr_burst;
    berr_beat = 1;
    toggle_go(4'b0010, 1'b0);
    observe(12);
    berr_beat = -1;
    LL_BERR   = 1'b0;
    checks++;
    if (obs_breq != 3 || obs_beat[2] !== 4'd1) begin
      errors++; $display("FAIL berr_abort got breq=%0d last_beat=%0d want 3 1", obs_breq, obs_beat[2]);
    end
    checks++;
    if (obs_ack != 1 || LD_BERR_R !== 1'b1) begin
      errors++; $display("FAIL berr_ack got ack=%0d berr=%b want 1 1", obs_ack, LD_BERR_R);
    end
  endtask

  task automatic test_back_to_back;
    int acks;
    toggle_go(4'b0010, 1'b0);
    observe(6);
    acks = obs_ack;
    toggle_go(4'b0010, 1'b0);
    observe(25);
    acks += obs_ack;
    checks++;
    if (acks != 2 || LD_BUSY !== 1'b0) begin
      errors++; $display("FAIL pending_toggle got acks=%0d busy=%b want 2 0", acks, LD_BUSY);
    end
  endtask

  task automatic test_sync_mode;
    @(negedge SYSCLK);
    LBCSYNCMODE = 1'b1;
    LC_CGO      = 1'b0;
    observe(3);
    @(negedge SYSCLK);
    LC_CQSEL = 4'b0100;
    LC_CGO   = 1'b1;
    observe(30);
    checks++;
    if (obs_first_busy != 1 || obs_ack != 1 || obs_breq != 2) begin
      errors++; $display("FAIL sync_level got busy_at=%0d ack=%0d breq=%0d want 1 1 2",
                         obs_first_busy, obs_ack, obs_breq);
    end
    LC_CGO = 1'b0;
    observe(3);
    checks++;
    if (obs_ack != 0 || obs_first_busy != -1) begin
      errors++; $display("FAIL sync_low got ack=%0d busy_at=%0d want 0 -1", obs_ack, obs_first_busy);
    end
    LC_CGO = 1'b1;
    observe(12);
    checks++;
    if (obs_ack != 1) begin errors++; $display("FAIL sync_second got ack=%0d want 1", obs_ack); end
  endtask

  task automatic test_reset_mid;
    @(negedge SYSCLK);
    LBCSYNCMODE = 1'b0;
    LL_BACK     = 1'b0;
    observe(3);
    toggle_go(4'b0100, 1'b0);
    observe(6);
    checks++;
    if (LD_BREQ !== 1'b1 || LD_BUSY !== 1'b1) begin
      errors++; $display("FAIL waitack_hold got breq=%b busy=%b want 1 1", LD_BREQ, LD_BUSY);
    end
    RESET_D1_R = 1'b1;
    #1;
    checks++;
    if (LD_BREQ !== 1'b0 || LD_BUSY !== 1'b0 || LDN_CGOACK_R !== 1'b0) begin
      errors++; $display("FAIL async_reset got breq=%b busy=%b ack=%b want 0 0 0", LD_BREQ, LD_BUSY, LDN_CGOACK_R);
    end
    @(negedge SYSCLK);
    RESET_D1_R = 1'b0;
    observe(10);
    checks++;
    if (obs_ack != 0 || obs_first_busy != -1) begin
      errors++; $display("FAIL post_reset got ack=%0d busy_at=%0d want 0 -1", obs_ack, obs_first_busy);
    end
  endtask

`ifdef LBC_LBUS_TIMEOUT_EN
  task automatic test_timeout;
    LL_BACK = 1'b0;
    toggle_go(4'b0010, 1'b0);
    observe(275);
    checks++;
    if (obs_breq != 257 || obs_ack != 1 || LD_BERR_R !== 1'b1) begin
      errors++; $display("FAIL timeout got breq=%0d ack=%0d berr=%b want 257 1 1", obs_breq, obs_ack, LD_BERR_R);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fetch_burst();
    test_ej_write();
    test_bad_select();
    test_berr_burst();
    test_back_to_back();
    test_sync_mode();
    test_reset_mid();
`ifdef LBC_LBUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lbc_lbus_resp.md
Name: lbc_lbus_resp

Overview:
- Responder end of the LBC go/ack handshake. Consumes the go toggle and one-hot source select from the CBUS-side controller.
- Runs the selected transfer on the local bus. Returns a one-cycle acknowledge pulse (LDN_CGOACK_R) and the EJTAG-destination flag (LD_MEJDEST) to the CBUS side.
- Sits between the CBUS controller and the local-bus interface logic.

Parameters:
- NSEL, 4, width of the source-select vector. Bit 0 = EJTAG DMA, 1 = instruction fetch, 2 = data read, 3 = write-buffer drain.
- IBURST, 4, beats per instruction-fetch transfer (1..16). All other sources are single-beat.
- TMO_W, 8, width of the watchdog counter (only used with the optional feature).

Ports:
- SYSCLK  in  1  system clock.
- RESET_D1_R  in  1  asynchronous, active-high reset.
- LBCSYNCMODE  in  1  1 = LC_CGO is a level; 0 = LC_CGO is a toggle and is synchronised here.
- LC_CGO  in  1  go indication from the CBUS side.
- LC_CQSEL  in  NSEL  one-hot source select; valid when go is detected.
- EJ_DMARW  in  1  EJTAG DMA direction (1 = read); sampled with the select.
- LL_BACK  in  1  local-bus beat acknowledge.
- LL_BERR  in  1  local-bus error; qualified by LL_BACK.
- LD_BREQ  out  1  local-bus request.
- LD_BRW  out  1  local-bus direction (1 = read).
- LD_BSRC  out  NSEL  registered copy of the select, driven for the whole transfer.
- LD_BEAT  out  4  current beat index.
- LD_MEJDEST  out  1  current transfer targets the EJTAG DMA.
- LDN_CGOACK_R  out  1  one-cycle completion pulse.
- LD_BERR_R  out  1  sticky error; cleared at the next accepted go.
- LD_BUSY  out  1  FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0. FSM = IDLE. Sync flops = 0. Previous-toggle register = 0.
- Go detect, async mode (LBCSYNCMODE=0):
  - LC_CGO passes through a 2-flop synchroniser.
  - go = sync2 XOR prev. prev updates every cycle.
  - Latency is 3 SYSCLK edges from LC_CGO changing to leaving IDLE.
- Go detect, sync mode (LBCSYNCMODE=1):
  - go = LC_CGO & ~LD_BUSY & ~ack_pending.
  - ack_pending is set by LDN_CGOACK_R and cleared when LC_CGO is seen low. This gives a level handshake with one transfer per high phase.
- FSM states: IDLE, LATCH, REQ, WAITACK, DONE.
- IDLE:
  - On go, register LC_CQSEL and EJ_DMARW, clear LD_BERR_R, go to LATCH.
  - A go while not IDLE is ignored in sync mode. In async mode it is held: one pending-toggle flag, consumed on return to IDLE.
- LATCH:
  - Decode the registered select.
  - If it is not one-hot (zero or multiple bits): set LD_BERR_R, go to DONE without touching the bus.
  - Else set LD_BRW: src1 = 1, src2 = 1, src3 = 0, src0 = EJ_DMARW.
  - Set LD_MEJDEST = src0. Load the beat counter with 0 and the limit with (src1 ? IBURST-1 : 0). Go to REQ.
- REQ: assert LD_BREQ, go to WAITACK.
- WAITACK:
  - LD_BREQ stays high.
  - On LL_BACK: OR LL_BERR into LD_BERR_R.
  - If beat == limit or LL_BERR: drop LD_BREQ, go to DONE. An error aborts the remaining beats.
  - Else beat+1 and stay in WAITACK. LD_BREQ stays asserted with no gap between beats.
- DONE:
  - LDN_CGOACK_R = 1 for exactly one cycle.
  - LD_MEJDEST is held through this cycle, then cleared. Go to IDLE.
- Simultaneous LL_BACK in the same cycle as leaving REQ: ignored. An ack counts only in WAITACK.
- Beat counter: 4 bits, wraps never (limit ≤ 15).
- Reset mid-transfer: immediate return to IDLE. LD_BREQ drops asynchronously. No ack is issued. The pending-toggle flag is cleared.

Optional Feature:
- Macro LBC_LBUS_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit counter clears on entry to WAITACK and on every LL_BACK, and increments otherwise.
  - At all-ones: set LD_BERR_R, drop LD_BREQ, go to DONE and issue the normal ack.
- Undefined: no counter. WAITACK waits indefinitely.

Decomposition:
- Shared package/include (alongside lxr_symbols): select bit indices (SRC_EJ=0, SRC_I=1, SRC_DR=2, SRC_DW=3), FSM state encodings, NSEL default.
- One sub-module: lbc_tgl_sync. It holds the 2-flop synchroniser plus the edge/level go detector selected by LBCSYNCMODE, and outputs go.

Test Plan:
- Async mode, LC_CGO 0→1, LC_CQSEL=4'b0010, LL_BACK on 4 consecutive cycles -> LD_BREQ high 5 cycles; LD_BRW=1; LD_BEAT 0,1,2,3; one LDN_CGOACK_R pulse; LD_MEJDEST=0.
- Async mode, select 4'b0001, EJ_DMARW=0 -> LD_BRW=0, LD_MEJDEST=1 through the ack cycle; single beat.
- Sync mode, LC_CGO held high across two transfer durations -> only one transfer and one ack; a second transfer only after LC_CGO goes low then high.
- Select 4'b0110 -> no LD_BREQ, LD_BERR_R=1, one ack pulse. Then a 4'b0100 go -> LD_BERR_R cleared, normal single read.
- Fetch burst with LL_BERR on beat 1 -> LD_BREQ drops after beat 1, LD_BERR_R=1, ack issued.
- RESET_D1_R asserted in WAITACK -> LD_BREQ=0 and LD_BUSY=0 immediately; no ack. With LBC_LBUS_TIMEOUT_EN and no LL_BACK -> ack after 2^TMO_W-1 cycles, LD_BERR_R=1.
